// File: rtl/adder_chain_pkg.sv
// Shared types, constants and sizing helpers for the adder-chain accumulator.
package adder_chain_pkg;

    // Storage type for the prime counter; the top checks that CNT_W fits it.
    localparam int PRIME_CNT_MAX_W = 8;
    typedef logic [PRIME_CNT_MAX_W-1:0] prime_cnt_t;

    // Sliced down to WIDTH by each adder when saturating.
    localparam logic [63:0] SAT_ALL_ONES = '1;

    function automatic int CNT_W(input int stages);
        return $clog2(stages + 2);
    endfunction

endpackage

// File: rtl/adder_chain_add.sv
// One WIDTH-bit adder of the chain with carry out.
// ADDER_CHAIN_SAT_EN: clamp the sum to all-ones on carry instead of wrapping.
module adder_chain_add
    import adder_chain_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] full;

    assign full  = {1'b0, a} + {1'b0, b};
    assign carry = full[WIDTH];

`ifdef ADDER_CHAIN_SAT_EN
    assign sum = carry ? SAT_ALL_ONES[WIDTH-1:0] : full[WIDTH-1:0];
`else
    assign sum = full[WIDTH-1:0];
`endif

endmodule

// File: rtl/adder_chain_accum.sv
// Feedback accumulator: a chain of STAGES+1 registered adders all fed by out,
// with valid/ready handshake, prime tracking and sticky overflow. Macro: ADDER_CHAIN_SAT_EN.
module adder_chain_accum
    import adder_chain_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             overflow
);

    localparam prime_cnt_t PRIME_FULL = prime_cnt_t'(STAGES + 1);

    if (WIDTH < 2 || STAGES < 1) begin : g_bad_param
        $error("adder_chain_accum: WIDTH must be >= 2 and STAGES >= 1");
    end
    if (CNT_W(STAGES) > PRIME_CNT_MAX_W) begin : g_bad_cnt
        $error("adder_chain_accum: STAGES too large for prime_cnt_t");
    end

    logic [STAGES-1:0][WIDTH-1:0] stage;
    logic [STAGES:0][WIDTH-1:0]   sum;
    logic [STAGES:0]              carry;
    prime_cnt_t                   prime_cnt;
    prime_cnt_t                   prime_next;
    logic                         step;

    assign in_ready   = !out_valid || out_ready;
    assign step       = in_valid && in_ready;
    assign prime_next = (prime_cnt == PRIME_FULL) ? prime_cnt : prime_cnt + 1'b1;

    // Adder k takes num (k==0) or stage[k-1]; the last adder feeds out.
    for (genvar k = 0; k <= STAGES; k++) begin : g_add
        logic [WIDTH-1:0] a_in;
        if (k == 0) begin : g_first
            assign a_in = num;
        end else begin : g_chain
            assign a_in = stage[k-1];
        end
        adder_chain_add #(.WIDTH(WIDTH)) u_add (
            .a     (a_in),
            .b     (out),
            .sum   (sum[k]),
            .carry (carry[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            stage     <= '0;
            out       <= '0;
            prime_cnt <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (step) begin
            stage     <= sum[STAGES-1:0];
            out       <= sum[STAGES];
            prime_cnt <= prime_next;
            out_valid <= (prime_next == PRIME_FULL);
            overflow  <= overflow | (|carry);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
